sram_responder: RTL and testbench

- Synthesizable responder (chip side) of the 16-bit asynchronous-style SRAM bus driven by the MEM-stage SRAM controller.
- Stands in for the external IS61-class SRAM in simulation and in FPGA builds without the board part.
- Decodes the active-low SRAM control strobes and stores 16-bit words with byte-lane masking.
- Returns read data on the shared tri-state data bus after a configurable latency, and keeps access statistics plus a protocol-violation flag for verification.

---
 rtl/sram_responder_if.sv | 28 ++
 rtl/sram_responder.sv | 135 +++++++++++++
 tb/tb_sram_responder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// Control half of the 16-bit asynchronous SRAM bus: word address plus active-low strobes.
// The shared data bus is a resolved net, so it stays a plain inout on the responder.
interface sram_responder_if;
  logic [17:0] sram_address;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_WE_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  modport master (
    output sram_address,
    output SRAM_UB_N,
    output SRAM_LB_N,
    output SRAM_WE_N,
    output SRAM_CE_N,
    output SRAM_OE_N
  );

  modport slave (
    input sram_address,
    input SRAM_UB_N,
    input SRAM_LB_N,
    input SRAM_WE_N,
    input SRAM_CE_N,
    input SRAM_OE_N
  );
endinterface

// File: rtl/sram_responder.sv
// Chip-side model of an IS61-class 16-bit SRAM: byte-masked writes, pipelined reads
// released combinationally on the live strobes, plus transaction counters and a conflict flag.
module sram_responder #(
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  inout  wire  [15:0]     sram_dq,
  sram_responder_if.slave bus,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count,
  output logic            conflict
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sram_responder: READ_LATENCY must be within 1..4");
  end

  typedef enum logic [1:0] {
    CLS_IDLE,
    CLS_READ,
    CLS_WRITE
  } cls_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic        ub;
    logic        lb;
  } rd_stage_t;

  logic [15:0]       mem_q [2**MEM_AW];
  rd_stage_t         pipe_q [READ_LATENCY];
  rd_stage_t         pipe_d [READ_LATENCY];
  cls_e              cls;
  cls_e              cls_q;
  logic [17:0]       addr_q;
  logic [15:0]       rd_count_q;
  logic [15:0]       rd_count_d;
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              conflict_q;
  logic              conflict_d;
  logic              txn_start;
  logic              rd_live;
  logic              drv_hi;
  logic              drv_lo;
  logic [MEM_AW-1:0] word_addr;
  rd_stage_t         pipe_out;

  assign word_addr = bus.sram_address[MEM_AW-1:0];

  always_comb begin
    cls = CLS_IDLE;
    if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) begin
      cls = CLS_WRITE;
    end else if (!bus.SRAM_CE_N && !bus.SRAM_OE_N) begin
      cls = CLS_READ;
    end
  end

  // Writes are gated by reset; memory itself is never cleared.
  always_ff @(posedge clk) begin
    if (rst && cls == CLS_WRITE) begin
      if (!bus.SRAM_UB_N) begin
        mem_q[word_addr][15:8] <= sram_dq[15:8];
      end
      if (!bus.SRAM_LB_N) begin
        mem_q[word_addr][7:0] <= sram_dq[7:0];
      end
    end
  end

  always_comb begin
    pipe_d[0].valid = (cls == CLS_READ);
    pipe_d[0].data  = mem_q[word_addr];
    pipe_d[0].ub    = !bus.SRAM_UB_N;
    pipe_d[0].lb    = !bus.SRAM_LB_N;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    txn_start  = (cls != CLS_IDLE) &&
                 ((cls != cls_q) || (bus.sram_address != addr_q));
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (txn_start && cls == CLS_READ && rd_count_q != 16'hFFFF) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (txn_start && cls == CLS_WRITE && wr_count_q != 16'hFFFF) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    conflict_d = conflict_q |
                 (!bus.SRAM_CE_N && !bus.SRAM_WE_N && !bus.SRAM_OE_N);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      cls_q      <= CLS_IDLE;
      addr_q     <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      cls_q      <= cls;
      addr_q     <= bus.sram_address;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      conflict_q <= conflict_d;
    end
  end

  // Drive enable uses only registered pipeline state and the live strobes, never the address.
  assign pipe_out = pipe_q[READ_LATENCY-1];
  assign rd_live  = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
  assign drv_hi   = pipe_out.valid && pipe_out.ub && rd_live;
  assign drv_lo   = pipe_out.valid && pipe_out.lb && rd_live;

  assign sram_dq[15:8] = drv_hi ? pipe_out.data[15:8] : 8'bz;
  assign sram_dq[7:0]  = drv_lo ? pipe_out.data[7:0]  : 8'bz;

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (latency 1 and 3) share stimulus; a reference
// model queues the expected bus/counter values and a negedge monitor compares them.
module tb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_ce, s_we, s_oe, s_ub, s_lb;
  logic [17:0] s_addr;
  logic [15:0] s_dat;
  logic        tb_drv;
  logic [15:0] rd1, wr1, rd3, wr3;
  logic        cf1, cf3;

  // Undriven bus bits read back as 1.
  tri1 [15:0] dq1;
  tri1 [15:0] dq3;
  assign dq1 = tb_drv ? s_dat : 16'bz;
  assign dq3 = tb_drv ? s_dat : 16'bz;

  sram_responder_if bus1 ();
  sram_responder_if bus3 ();
  assign bus1.sram_address = s_addr;
  assign bus1.SRAM_UB_N    = s_ub;
  assign bus1.SRAM_LB_N    = s_lb;
  assign bus1.SRAM_WE_N    = s_we;
  assign bus1.SRAM_CE_N    = s_ce;
  assign bus1.SRAM_OE_N    = s_oe;
  assign bus3.sram_address = s_addr;
  assign bus3.SRAM_UB_N    = s_ub;
  assign bus3.SRAM_LB_N    = s_lb;
  assign bus3.SRAM_WE_N    = s_we;
  assign bus3.SRAM_CE_N    = s_ce;
  assign bus3.SRAM_OE_N    = s_oe;

  sram_responder #(.MEM_AW(10), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .sram_dq(dq1), .bus(bus1),
    .rd_count(rd1), .wr_count(wr1), .conflict(cf1)
  );

  sram_responder #(.MEM_AW(10), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .sram_dq(dq3), .bus(bus3),
    .rd_count(rd3), .wr_count(wr3), .conflict(cf3)
  );

  typedef struct {
    int          edge_no;
    bit          v;
    logic [15:0] d;
    bit          ub;
    bit          lb;
  } hrec_t;

  typedef struct {
    logic [15:0] dq1;
    logic [15:0] dq3;
    logic [15:0] rd;
    logic [15:0] wr;
    logic        cf;
  } exp_t;

  // Reference model state
  logic [15:0] m_mem [1024];
  hrec_t       hist [8];
  int          n_edge = 0;
  int          last_rst = 0;
  bit          model_ok = 0;
  logic [15:0] m_rd, m_wr;
  logic        m_cf;
  int          m_prev_cls;
  logic [17:0] m_prev_addr;
  exp_t        sb [$];

  int total = 0;
  int bad = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Bus value seen during the current cycle for a responder of latency lat.
  function automatic logic [15:0] exp_bus(input int lat);
    logic [15:0] v;
    int e;
    hrec_t h;
    if (!s_we) return s_dat;
    v = 16'hFFFF;
    e = n_edge - lat + 1;
    h = hist[e & 7];
    if (h.edge_no == e && e > last_rst && h.v && !s_ce && s_we && !s_oe) begin
      if (h.ub) v[15:8] = h.d[15:8];
      if (h.lb) v[7:0]  = h.d[7:0];
    end
    return v;
  endfunction

  task automatic push_expect();
    exp_t x;
    x.dq1 = exp_bus(1);
    x.dq3 = exp_bus(3);
    x.rd  = m_rd;
    x.wr  = m_wr;
    x.cf  = m_cf;
    sb.push_back(x);
  endtask

  task automatic model_edge();
    int cls;
    hrec_t h;
    n_edge++;
    h.edge_no = n_edge;
    h.v = 0; h.d = '0; h.ub = 0; h.lb = 0;
    if (!rst) begin
      m_rd = '0; m_wr = '0; m_cf = 1'b0;
      m_prev_cls = 0;
      last_rst = n_edge;
      model_ok = 1;
    end else begin
      if (!s_ce && !s_we)      cls = 2;
      else if (!s_ce && !s_oe) cls = 1;
      else                     cls = 0;
      if (cls == 1) begin
        h.v = 1; h.d = m_mem[s_addr[9:0]]; h.ub = !s_ub; h.lb = !s_lb;
      end
      if (cls == 2) begin
        if (!s_ub) m_mem[s_addr[9:0]][15:8] = s_dat[15:8];
        if (!s_lb) m_mem[s_addr[9:0]][7:0]  = s_dat[7:0];
      end
      if (cls != 0 && (cls != m_prev_cls || s_addr != m_prev_addr)) begin
        if (cls == 1 && m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
        if (cls == 2 && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
      end
      if (!s_ce && !s_we && !s_oe) m_cf = 1'b1;
      m_prev_cls  = cls;
      m_prev_addr = s_addr;
    end
    hist[n_edge & 7] = h;
  endtask

  // One bus cycle: apply inputs, queue the expectation, then advance the model at the edge.
  task automatic drive(input logic r, input logic ce, input logic we, input logic oe,
                       input logic ub, input logic lb, input logic [17:0] a,
                       input logic [15:0] d);
    rst = r; s_ce = ce; s_we = we; s_oe = oe; s_ub = ub; s_lb = lb;
    s_addr = a; s_dat = d; tb_drv = !we;
    if (model_ok) push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr_c(input logic [17:0] a, input logic [15:0] d,
                      input logic ub = 1'b0, input logic lb = 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, ub, lb, a, d);
  endtask

  task automatic rd_c(input logic [17:0] a, input logic ub = 1'b0, input logic lb = 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0000);
  endtask

  task automatic idle_c();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0000);
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("dq_lat1", dq1, e.dq1);
        cmp("dq_lat3", dq3, e.dq3);
        cmp("rd_count_lat1", rd1, e.rd);
        cmp("wr_count_lat1", wr1, e.wr);
        cmp("conflict_lat1", {15'd0, cf1}, {15'd0, e.cf});
        cmp("rd_count_lat3", rd3, e.rd);
        cmp("wr_count_lat3", wr3, e.wr);
        cmp("conflict_lat3", {15'd0, cf3}, {15'd0, e.cf});
      end
    end
  end

  initial begin
    int          op;
    int          reps;
    logic [17:0] a;
    logic [15:0] d;
    logic [2:0]  rb;

    for (int i = 0; i < 8; i++) hist[i].edge_no = -1;
    rst = 1'b0; s_ce = 1'b1; s_we = 1'b1; s_oe = 1'b1; s_ub = 1'b1; s_lb = 1'b1;
    s_addr = '0; s_dat = '0; tb_drv = 1'b0;

    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
    cmp("reset_rd_count", rd1, 16'h0000);
    cmp("reset_conflict", {15'd0, cf3}, 16'h0000);

    // Write then read
    wr_c(18'h00005, 16'hA55A);
    wr_c(18'h00005, 16'hA55A);
    rd_c(18'h00005);
    rd_c(18'h00005);
    rd_c(18'h00005);
    cmp("t1_wr_count", wr1, 16'd1);
    cmp("t1_rd_count", rd1, 16'd1);
    idle_c();

    // Byte masking
    wr_c(18'h7, 16'h1234);
    idle_c();
    wr_c(18'h7, 16'hFF00, 1'b0, 1'b1);
    idle_c();
    rd_c(18'h7);
    idle_c();
    rd_c(18'h7, 1'b1, 1'b0);
    rd_c(18'h7, 1'b1, 1'b0);
    idle_c();

    // Latency and release
    wr_c(18'h2, 16'hBEEF);
    idle_c();
    rd_c(18'h2);
    rd_c(18'h2);
    rd_c(18'h2);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h2, 16'h0);
    idle_c();

    // Conflict and aliasing
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00400, 16'h0F0F);
    idle_c();
    rd_c(18'h0);
    rd_c(18'h0);
    idle_c();
    cmp("t4_conflict_lat1", {15'd0, cf1}, 16'h0001);
    cmp("t4_conflict_lat3", {15'd0, cf3}, 16'h0001);

    // Reset during an active read; a write during reset must be ignored
    rd_c(18'h5);
    rd_c(18'h5);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h5, 16'h0);
    cmp("t5_rd_count", rd1, 16'h0000);
    cmp("t5_wr_count", wr3, 16'h0000);
    cmp("t5_conflict", {15'd0, cf1}, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h5, 16'h0000);
    rd_c(18'h5);
    rd_c(18'h5);
    rd_c(18'h5);
    rd_c(18'h5);
    idle_c();

    // Fill memory so random reads see defined data
    for (int i = 0; i < 1024; i++) begin
      d = 16'($urandom);
      wr_c(18'(i), d);
    end

    // Randomised traffic including aliasing addresses, lane masks, conflicts and resets
    for (int i = 0; i < 1500; i++) begin
      op   = $urandom_range(0, 99);
      reps = $urandom_range(1, 3);
      a    = 18'($urandom_range(0, 15)) | (18'($urandom_range(0, 3)) << 10)
             | (18'($urandom_range(0, 1)) << 17);
      d    = 16'($urandom);
      rb   = 3'($urandom_range(0, 7));
      for (int k = 0; k < reps; k++) begin
        if (op < 2)       drive(1'b0, rb[0], rb[1], rb[2], 1'b0, 1'b0, a, d);
        else if (op < 5)  drive(1'b1, 1'b0, 1'b0, 1'b0, rb[0], rb[1], a, d);
        else if (op < 40) wr_c(a, d, rb[0], rb[1]);
        else if (op < 80) rd_c(a, rb[0], rb[1]);
        else drive(1'b1, rb[0], rb[1], rb[2], 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), a, d);
      end
    end

    // Saturation
    idle_c();
    for (int i = 0; i < 65537; i++) rd_c(18'(i & 1));
    idle_c();
    cmp("sat_rd_count_lat1", rd1, 16'hFFFF);
    cmp("sat_rd_count_lat3", rd3, 16'hFFFF);
    idle_c();
    idle_c();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
